// File: rtl/player_pkg.sv
// Shared constants, state encoding and ship-position clamp helper for the
// player datapath.
package player_pkg;

    localparam int unsigned SCREEN_W = 32'd160;
    localparam int unsigned SCREEN_H = 32'd120;
    localparam int unsigned X_W      = 32'd8;
    localparam int unsigned Y_W      = 32'd7;
    localparam int unsigned COLOUR_W = 32'd3;
    localparam int unsigned COL_W    = 32'd3;
    localparam int unsigned ROW_W    = 32'd3;

    localparam int unsigned SHIP_W = 32'd8;
    localparam int unsigned SHIP_H = 32'd6;

    localparam logic [X_W-1:0]   SHIP_X   = 8'd8;
    localparam logic [COL_W-1:0] COL_LAST = 3'd7;
    localparam logic [ROW_W-1:0] ROW_LAST = 3'd5;

    localparam logic [Y_W-1:0] Y_MIN  = 7'd0;
    localparam logic [Y_W-1:0] Y_MAX  = 7'd114;
    localparam logic [Y_W-1:0] Y_INIT = 7'd57;
    localparam logic [Y_W-1:0] STEP   = 7'd2;

    localparam logic [COLOUR_W-1:0] SHIP_COLOUR = 3'b111;
    localparam logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ERASE  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_DRAW   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Comparisons widened to 8 bits so the step can never wrap past either limit.
    function automatic logic [Y_W-1:0] next_ship_y(input logic [Y_W-1:0] y,
                                                   input logic up);
        logic [X_W-1:0] y8;
        y8 = {1'b0, y};
        if (up) begin
            if (y8 < ({1'b0, Y_MIN} + {1'b0, STEP})) return Y_MIN;
            else                                      return y - STEP;
        end else begin
            if (y8 > ({1'b0, Y_MAX} - {1'b0, STEP})) return Y_MAX;
            else                                      return y + STEP;
        end
    endfunction

endpackage

// File: rtl/player_datapath_sprite_scan.sv
// Row-major column/row counter over the ship sprite, shared by erase and draw.
module sprite_scan
    import player_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    assign col  = col_r;
    assign row  = row_r;
    assign last = (col_r == COL_LAST) && (row_r == ROW_LAST);

    // Advance one pixel per enabled cycle; wraps to the origin after the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= 3'd0;
            row_r <= 3'd0;
        end else if (clear) begin
            col_r <= 3'd0;
            row_r <= 3'd0;
        end else if (enable) begin
            if (col_r == COL_LAST) begin
                col_r <= 3'd0;
                row_r <= (row_r == ROW_LAST) ? 3'd0 : row_r + 3'd1;
            end else begin
                col_r <= col_r + 3'd1;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

endmodule

// File: rtl/player_datapath.sv
// Player ship datapath: accepts move/redraw strobes, clamps the ship row and
// streams erase-then-draw pixel writes to the VGA adapter.
module player_datapath
    import player_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                move_up,
    input  logic                move_down,
    input  logic                redraw,
    output logic                busy,
    output logic                done,
    output logic [Y_W-1:0]      ship_y,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    state_t           state_r;
    state_t           state_next_s;
    logic [Y_W-1:0]   ship_y_r;
    logic             dir_up_r;
    logic             move_one_s;
    logic             at_limit_s;
    logic             scan_last_s;
    logic [COL_W-1:0] col_s;
    logic [ROW_W-1:0] row_s;

    sprite_scan u_scan (
        .clk    (clk),
        .rst_n  (reset_n),
        .clear  (state_r == ST_IDLE),
        .enable (vga_plot),
        .col    (col_s),
        .row    (row_s),
        .last   (scan_last_s)
    );

    // Next-state decode; opposing move strobes cancel, moves outrank redraw.
    always_comb begin
        state_next_s = state_r;
        move_one_s   = move_up ^ move_down;
        at_limit_s   = move_up ? (ship_y_r == Y_MIN) : (ship_y_r == Y_MAX);
        case (state_r)
            ST_IDLE: begin
                if (move_one_s) begin
                    state_next_s = at_limit_s ? ST_DONE : ST_ERASE;
                end else if (redraw && !move_up && !move_down) begin
                    state_next_s = ST_DRAW;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ERASE: begin
                if (scan_last_s) state_next_s = ST_UPDATE;
                else             state_next_s = ST_ERASE;
            end
            ST_UPDATE: state_next_s = ST_DRAW;
            ST_DRAW: begin
                if (scan_last_s) state_next_s = ST_DONE;
                else             state_next_s = ST_DRAW;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, latched direction and ship row registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            ship_y_r <= Y_INIT;
            dir_up_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_IDLE && move_one_s) dir_up_r <= move_up;
            else                                  dir_up_r <= dir_up_r;
            if (state_r == ST_UPDATE) ship_y_r <= next_ship_y(ship_y_r, dir_up_r);
            else                      ship_y_r <= ship_y_r;
        end
    end

    assign busy       = (state_r != ST_IDLE);
    assign done       = (state_r == ST_DONE);
    assign vga_plot   = (state_r == ST_ERASE) || (state_r == ST_DRAW);
    assign vga_colour = (state_r == ST_DRAW) ? SHIP_COLOUR : BG_COLOUR;
    assign vga_x      = SHIP_X + {5'b00000, col_s};
    assign vga_y      = ship_y_r + {4'b0000, row_s};
    assign ship_y     = ship_y_r;

endmodule

// File: tb/tb_player_datapath.sv
// Directed bench for player_datapath: command vector table plus hand-built
// clamp, busy-drop and mid-erase reset sequences.
module tb_player_datapath;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       move_up = 1'b0;
    logic       move_down = 1'b0;
    logic       redraw = 1'b0;
    logic       busy;
    logic       done;
    logic [6:0] ship_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int n_pass = 0;
    int n_total = 0;

    player_datapath dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .move_up    (move_up),
        .move_down  (move_down),
        .redraw     (redraw),
        .busy       (busy),
        .done       (done),
        .ship_y     (ship_y),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  mu;
        logic  md;
        logic  rd;
        int    y0;
        int    y1;
        int    n_er;
        int    n_dr;
        int    done_at;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Issue one strobe and watch 110 cycles; k counts cycles after acceptance.
    task automatic run_cmd(input vec_t v);
        int e, d, dn_cnt, dn_k, bad, ds;
        e = 0; d = 0; dn_cnt = 0; dn_k = -1; bad = 0;
        ds = (v.n_er > 0) ? 50 : 1;
        @(negedge clk);
        move_up = v.mu; move_down = v.md; redraw = v.rd;
        for (int k = 1; k <= 110; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                move_up = 1'b0; move_down = 1'b0; redraw = 1'b0;
            end
            if (vga_plot) begin
                if (vga_colour == 3'b000 && e < v.n_er) begin
                    if (k != 1 + e || int'(vga_x) != 8 + e % 8 || int'(vga_y) != v.y0 + e / 8) bad++;
                    e++;
                end else if (vga_colour == 3'b111 && d < v.n_dr) begin
                    if (k != ds + d || int'(vga_x) != 8 + d % 8 || int'(vga_y) != v.y1 + d / 8) bad++;
                    d++;
                end else begin
                    bad++;
                end
            end
            if (v.done_at == 0 && busy) bad++;
            if (done) begin
                dn_cnt++;
                dn_k = k;
            end
            if (k == 50 && v.n_er > 0) check({v.name, " ship_y@T+50"}, int'(ship_y), v.y1);
        end
        check({v.name, " erase plots"}, e, v.n_er);
        check({v.name, " draw plots"}, d, v.n_dr);
        check({v.name, " pixel errors"}, bad, 0);
        check({v.name, " done count"}, dn_cnt, (v.done_at > 0) ? 1 : 0);
        if (v.done_at > 0) check({v.name, " done cycle"}, dn_k, v.done_at);
        check({v.name, " final ship_y"}, int'(ship_y), v.y1);
        check({v.name, " idle at end"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    vec_t tbl[5];
    vec_t v;
    int   y;
    int   dn_cnt, dn_k, d;

    initial begin
        tbl[0] = '{"redraw",        1'b0, 1'b0, 1'b1, 57, 57, 0,  48, 49};
        tbl[1] = '{"down 57",       1'b0, 1'b1, 1'b0, 57, 59, 48, 48, 98};
        tbl[2] = '{"up 59",         1'b1, 1'b0, 1'b0, 59, 57, 48, 48, 98};
        tbl[3] = '{"up+down",       1'b1, 1'b1, 1'b0, 57, 57, 0,  0,  0};
        tbl[4] = '{"up+redraw",     1'b1, 1'b0, 1'b1, 57, 55, 48, 48, 98};

        #12;
        check("reset ship_y", int'(ship_y), 57);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset plot", int'(vga_plot), 0);
        check("reset vga_x", int'(vga_x), 8);
        check("reset vga_y", int'(vga_y), 57);
        check("reset colour", int'(vga_colour), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_cmd(tbl[i]);

        // Walk up to row 1, then clamp to 0, then hit the top limit.
        y = 55;
        while (y > 1) begin
            v = '{"walk up", 1'b1, 1'b0, 1'b0, y, y - 2, 48, 48, 98};
            run_cmd(v);
            y = y - 2;
        end
        v = '{"clamp up 1", 1'b1, 1'b0, 1'b0, 1, 0, 48, 48, 98};
        run_cmd(v);
        v = '{"limit up 0", 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1};
        run_cmd(v);

        // move_up during DRAW must be dropped.
        dn_cnt = 0; dn_k = -1; d = 0;
        @(negedge clk);
        redraw = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            @(posedge clk); #1;
            if (k == 1) redraw = 1'b0;
            if (k == 10) move_up = 1'b1;
            if (k == 11) move_up = 1'b0;
            if (vga_plot) d++;
            if (done) begin
                dn_cnt++;
                dn_k = k;
            end
        end
        check("busy drop done count", dn_cnt, 1);
        check("busy drop done cycle", dn_k, 49);
        check("busy drop plots", d, 48);
        check("busy drop ship_y", int'(ship_y), 0);

        // Walk down to 113, clamp to 114, then hit the bottom limit.
        do_reset();
        y = 57;
        while (y < 113) begin
            v = '{"walk down", 1'b0, 1'b1, 1'b0, y, y + 2, 48, 48, 98};
            run_cmd(v);
            y = y + 2;
        end
        v = '{"clamp down 113", 1'b0, 1'b1, 1'b0, 113, 114, 48, 48, 98};
        run_cmd(v);
        v = '{"limit down 114", 1'b0, 1'b1, 1'b0, 114, 114, 0, 0, 1};
        run_cmd(v);

        // Reset during ERASE cycle 20 of a move from 59.
        do_reset();
        v = '{"down to 59", 1'b0, 1'b1, 1'b0, 57, 59, 48, 48, 98};
        run_cmd(v);
        @(negedge clk);
        move_down = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) move_down = 1'b0;
        end
        check("pre-reset plot", int'(vga_plot), 1);
        reset_n = 1'b0;
        #1;
        check("mid reset busy", int'(busy), 0);
        check("mid reset plot", int'(vga_plot), 0);
        check("mid reset ship_y", int'(ship_y), 57);
        @(negedge clk);
        reset_n = 1'b1;
        v = '{"redraw after reset", 1'b0, 1'b0, 1'b1, 57, 57, 0, 48, 49};
        run_cmd(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
